// File: rtl/checkpoint_seq_monitor.sv
// Checkpoint sequence monitor for the mprj_io checkbits bus.
// Filters glitches and checks an ordered code list against a cycle budget.
module checkpoint_seq_monitor #(
  parameter int unsigned DW         = 16,
  parameter int unsigned N_CP       = 8,
  parameter int unsigned TMO_W      = 20,
  parameter int unsigned TMO_CYC    = 350000,
  parameter int unsigned TMO_PER_CP = 0,
  parameter int unsigned STABLE_CYC = 2,
  localparam int unsigned IW = (N_CP > 1) ? $clog2(N_CP) : 1,
  localparam int unsigned LW = $clog2(N_CP + 1)
) (
  input  logic          clock,
  input  logic          RSTB,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [DW-1:0] cfg_code,
  input  logic [LW-1:0] cfg_len,
  input  logic          strict,
  input  logic          start,
  input  logic [DW-1:0] checkbits,
  output logic          busy,
  output logic          pass,
  output logic          fail,
  output logic [1:0]    err,
  output logic          cp_hit,
  output logic [LW-1:0] cp_idx
);

  localparam int unsigned SW = (STABLE_CYC > 0) ? $clog2(STABLE_CYC + 1) : 1;
  localparam logic [SW-1:0]    StableMax = SW'(STABLE_CYC);
  localparam logic [TMO_W-1:0] TmoLoad   = TMO_W'(TMO_CYC);
  localparam logic [LW-1:0]    LenMax    = LW'(N_CP);
  localparam logic [1:0]       ErrNone   = 2'd0;
  localparam logic [1:0]       ErrTmo    = 2'd1;
  localparam logic [1:0]       ErrSkip   = 2'd2;

  typedef enum logic [1:0] {StIdle, StRun, StPass, StFail} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    code_q [N_CP];
  logic [DW-1:0]    code_d [N_CP];
  logic [DW-1:0]    smp_q, smp_d;
  logic [SW-1:0]    stab_q, stab_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [LW-1:0]    idx_q, idx_d;
  logic [LW-1:0]    len_q, len_d;
  logic             strict_q, strict_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [1:0]       err_q, err_d;
  logic             hit_q, hit_d;

  logic          acc_ev;
  logic          hit;
  logic          skip_match;
  logic [DW-1:0] exp_code;

  // Glitch filter: stability count saturates, so each settled value yields one event.
  always_comb begin
    smp_d  = checkbits;
    stab_d = stab_q;
    if (checkbits != smp_q) begin
      stab_d = '0;
    end else if (stab_q != StableMax) begin
      stab_d = stab_q + SW'(1);
    end
    acc_ev = (stab_q == StableMax) && (smp_q != acc_q);
  end

  always_comb begin
    exp_code   = '0;
    skip_match = 1'b0;
    for (int unsigned j = 0; j < N_CP; j++) begin
      if (LW'(j) == idx_q) begin
        exp_code = code_q[j];
      end
      // Only entries still ahead of the expected one count as a skip.
      if ((LW'(j) > idx_q) && (LW'(j) < len_q) && (code_q[j] == smp_q)) begin
        skip_match = 1'b1;
      end
    end
    hit = (state_q == StRun) && acc_ev && (idx_q < len_q) && (smp_q == exp_code);
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    acc_d    = acc_ev ? smp_q : acc_q;
    idx_d    = idx_q;
    len_d    = len_q;
    strict_d = strict_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    hit_d    = 1'b0;

    if (cfg_we && (state_q != StRun)) begin
      for (int unsigned j = 0; j < N_CP; j++) begin
        if (IW'(j) == cfg_idx) begin
          code_d[j] = cfg_code;
        end
      end
    end

    unique case (state_q)
      StRun: begin
        if (tmo_q != '0) begin
          tmo_d = tmo_q - TMO_W'(1);
        end
        if (len_q == '0) begin
          state_d = StPass;
        end else if (hit) begin
          // A hit outranks a coincident timeout.
          hit_d = 1'b1;
          idx_d = idx_q + LW'(1);
          if (TMO_PER_CP != 0) begin
            tmo_d = TmoLoad;
          end
          if (idx_d == len_q) begin
            state_d = StPass;
          end
        end else if (strict_q && acc_ev && skip_match) begin
          state_d = StFail;
          err_d   = ErrSkip;
        end else if (tmo_q <= TMO_W'(1)) begin
          state_d = StFail;
          err_d   = ErrTmo;
        end
      end
      StIdle, StPass, StFail: begin
        if (start) begin
          state_d  = StRun;
          idx_d    = '0;
          err_d    = ErrNone;
          tmo_d    = TmoLoad;
          len_d    = (cfg_len > LenMax) ? LenMax : cfg_len;
          strict_d = strict;
          acc_d    = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge RSTB) begin
    if (!RSTB) begin
      state_q  <= StIdle;
      code_q   <= '{default: '0};
      smp_q    <= '0;
      stab_q   <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      strict_q <= 1'b0;
      tmo_q    <= '0;
      err_q    <= ErrNone;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      smp_q    <= smp_d;
      stab_q   <= stab_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      strict_q <= strict_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      hit_q    <= hit_d;
    end
  end

  assign busy   = (state_q == StRun);
  assign pass   = (state_q == StPass);
  assign fail   = (state_q == StFail);
  assign err    = err_q;
  assign cp_hit = hit_q;
  assign cp_idx = idx_q;

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Randomized and directed bench for checkpoint_seq_monitor; two instances
// (whole-run and per-checkpoint budget) share stimulus and a reference model.
module tb_checkpoint_seq_monitor;

  localparam int NCp = 8;
  localparam int Tmo = 100;
  localparam int Sc  = 2;
  localparam int MIdle = 0, MRun = 1, MPass = 2, MFail = 3;

  logic        clock = 1'b0;
  logic        RSTB = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_idx = '0;
  logic [15:0] cfg_code = '0;
  logic [3:0]  cfg_len = '0;
  logic        strict = 1'b0;
  logic        start = 1'b0;
  logic [15:0] checkbits = '0;

  logic       busy0, pass0, fail0, hit0, busy1, pass1, fail1, hit1;
  logic [1:0] err0, err1;
  logic [3:0] idx0, idx1;

  always #5 clock = ~clock;

  checkpoint_seq_monitor #(
    .DW(16), .N_CP(NCp), .TMO_W(20), .TMO_CYC(Tmo), .TMO_PER_CP(0), .STABLE_CYC(Sc)
  ) u_dut0 (
    .clock(clock), .RSTB(RSTB), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_code(cfg_code),
    .cfg_len(cfg_len), .strict(strict), .start(start), .checkbits(checkbits),
    .busy(busy0), .pass(pass0), .fail(fail0), .err(err0), .cp_hit(hit0), .cp_idx(idx0)
  );

  checkpoint_seq_monitor #(
    .DW(16), .N_CP(NCp), .TMO_W(20), .TMO_CYC(Tmo), .TMO_PER_CP(1), .STABLE_CYC(Sc)
  ) u_dut1 (
    .clock(clock), .RSTB(RSTB), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_code(cfg_code),
    .cfg_len(cfg_len), .strict(strict), .start(start), .checkbits(checkbits),
    .busy(busy1), .pass(pass1), .fail(fail1), .err(err1), .cp_hit(hit1), .cp_idx(idx1)
  );

  logic [9:0] st0, st1;
  assign st0 = {busy0, pass0, fail0, err0, hit0, idx0};
  assign st1 = {busy1, pass1, fail1, err1, hit1, idx1};

  int n_checks = 0;
  int n_errs   = 0;
  int hits0    = 0;

  // Reference model: run-level view of the rules, one step per clock edge.
  int          m_state[2], m_idx[2], m_len[2], m_elapsed[2], m_err[2];
  bit          m_strict[2], m_hit[2];
  logic [15:0] m_acc[2];
  logic [15:0] m_code[2][NCp];
  logic [15:0] smp_hist[$];
  logic [15:0] tbl[NCp];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = MIdle; m_idx[i] = 0; m_len[i] = 0; m_elapsed[i] = 0; m_err[i] = 0;
      m_strict[i] = 1'b0; m_hit[i] = 1'b0; m_acc[i] = '0;
      for (int j = 0; j < NCp; j++) m_code[i][j] = '0;
    end
    smp_hist.delete();
    smp_hist.push_back(16'h0);
  endfunction

  function automatic bit later_entry(input int i, input logic [15:0] v);
    for (int j = m_idx[i] + 1; j < m_len[i]; j++) if (m_code[i][j] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_step();
    logic [15:0] v;
    bit          stable, ev;
    int          old_st;
    v = smp_hist[$];
    stable = (smp_hist.size() == Sc + 1);
    foreach (smp_hist[k]) if (smp_hist[k] != v) stable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ev = stable && (v != m_acc[i]);
      old_st = m_state[i];
      m_hit[i] = 1'b0;
      if (old_st == MRun) begin
        m_elapsed[i]++;
        if (m_len[i] == 0) begin
          m_state[i] = MPass;
        end else if (ev && v == m_code[i][m_idx[i]]) begin
          m_hit[i] = 1'b1;
          m_idx[i]++;
          if (i == 1) m_elapsed[i] = 0;
          if (m_idx[i] == m_len[i]) m_state[i] = MPass;
        end else if (ev && m_strict[i] && later_entry(i, v)) begin
          m_state[i] = MFail; m_err[i] = 2;
        end else if (m_elapsed[i] >= Tmo) begin
          m_state[i] = MFail; m_err[i] = 1;
        end
      end
      if (ev) m_acc[i] = v;
      if (old_st != MRun) begin
        if (cfg_we) m_code[i][cfg_idx] = cfg_code;
        if (start) begin
          m_state[i] = MRun; m_idx[i] = 0; m_err[i] = 0; m_elapsed[i] = 0;
          m_len[i] = (cfg_len > NCp) ? NCp : int'(cfg_len);
          m_strict[i] = strict; m_acc[i] = '0;
        end
      end
    end
    smp_hist.push_back(checkbits);
    if (smp_hist.size() > Sc + 1) void'(smp_hist.pop_front());
  endfunction

  function automatic logic [9:0] exp_status(input int i);
    return {m_state[i] == MRun, m_state[i] == MPass, m_state[i] == MFail,
            2'(m_err[i]), m_hit[i], 4'(m_idx[i])};
  endfunction

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_eq("status0", 32'(st0), 32'(exp_status(0)));
    check_eq("status1", 32'(st1), 32'(exp_status(1)));
    if (hit0) hits0++;
  endtask

  task automatic hold(input logic [15:0] v, input int n);
    checkbits = v;
    repeat (n) tick();
  endtask

  task automatic program_tbl(input int n);
    for (int j = 0; j < n; j++) begin
      cfg_we = 1'b1; cfg_idx = 3'(j); cfg_code = tbl[j];
      tick();
    end
    cfg_we = 1'b0;
  endtask

  task automatic do_start(input int len, input bit s);
    cfg_len = 4'(len); strict = s; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_basic();
    tbl[0] = 16'hAB40; tbl[1] = 16'h003E; tbl[2] = 16'h0044;
    tbl[3] = 16'h004A; tbl[4] = 16'h0050; tbl[5] = 16'hAB51;
    program_tbl(6);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bc;
    model_reset();
    #2;
    check_eq("reset0", 32'(st0), 32'h0);
    check_eq("reset1", 32'(st1), 32'h0);
    @(negedge clock);
    RSTB = 1'b1;

    // Basic pass, then the same again as a re-arm from PASS.
    for (int r = 0; r < 2; r++) begin
      load_basic();
      hits0 = 0;
      do_start(6, 1'b0);
      for (int j = 0; j < 6; j++) hold(tbl[j], 10);
      check_eq("basic_pass", 32'(pass0), 32'd1);
      check_eq("basic_err", 32'(err0), 32'd0);
      check_eq("basic_idx", 32'(idx0), 32'd6);
      check_eq("basic_hits", 32'(hits0), 32'd6);
      hold(16'h0, 5);
    end

    // Glitch rejection.
    do_start(6, 1'b0);
    hold(16'hAB40, 10);
    hold(16'h003E, 1);
    hold(16'h0000, 10);
    check_eq("glitch_idx", 32'(idx0), 32'd1);
    hold(16'h003E, 5);
    check_eq("glitch_held", 32'(idx0), 32'd2);
    hold(16'h0, 110);

    // Skip detection, strict and non-strict.
    do_start(6, 1'b1);
    hold(16'hAB40, 10);
    hold(16'h0044, 10);
    check_eq("skip_fail", 32'(fail0), 32'd1);
    check_eq("skip_err", 32'(err0), 32'd2);
    check_eq("skip_idx", 32'(idx0), 32'd1);
    hold(16'h0, 5);
    do_start(6, 1'b0);
    hold(16'hAB40, 10);
    hold(16'h0044, 10);
    check_eq("noskip_busy", 32'(busy0), 32'd1);
    hold(16'h003E, 10);
    check_eq("noskip_idx", 32'(idx0), 32'd2);
    hold(16'h0, 110);

    // Whole-run timeout.
    do_start(6, 1'b0);
    bc = 0;
    checkbits = 16'hAB40;
    repeat (120) begin
      tick();
      if (busy0) bc++;
    end
    check_eq("tmo_busy_cycles", 32'(bc), 32'(Tmo - 1));
    check_eq("tmo_fail", 32'(fail0), 32'd1);
    check_eq("tmo_err", 32'(err0), 32'd1);
    hold(16'h0, 5);

    // Per-checkpoint budget with hits every 80 cycles.
    do_start(6, 1'b0);
    for (int j = 0; j < 6; j++) hold(tbl[j], 80);
    check_eq("percp_pass1", 32'(pass1), 32'd1);
    check_eq("percp_fail0", 32'(fail0), 32'd1);
    hold(16'h0, 5);

    // Zero-length list.
    do_start(0, 1'b0);
    check_eq("len0_busy", 32'(busy0), 32'd1);
    tick();
    check_eq("len0_pass", 32'(pass0), 32'd1);
    check_eq("len0_idx", 32'(idx0), 32'd0);

    // Duplicate consecutive codes.
    tbl[0] = 16'h0044; tbl[1] = 16'h0044; tbl[2] = 16'h0050;
    program_tbl(3);
    do_start(3, 1'b0);
    hold(16'h0044, 20);
    check_eq("dup_first", 32'(idx0), 32'd1);
    hold(16'h0, 10);
    hold(16'h0044, 10);
    check_eq("dup_second", 32'(idx0), 32'd2);
    hold(16'h0050, 10);
    check_eq("dup_pass", 32'(pass0), 32'd1);
    hold(16'h0, 5);

    // Final hit exactly on the timeout cycle, then one cycle too late.
    tbl[0] = 16'h0077;
    program_tbl(1);
    for (int late = 0; late < 2; late++) begin
      checkbits = 16'h0;
      do_start(1, 1'b0);
      repeat (96 + late) tick();
      hold(16'h0077, 5);
      check_eq("edge_pass", 32'(pass0), late ? 32'd0 : 32'd1);
      check_eq("edge_err", 32'(err0), late ? 32'd1 : 32'd0);
      hold(16'h0, 110);
    end

    // Reset mid-run clears everything, including the code table.
    load_basic();
    do_start(6, 1'b0);
    hold(16'hAB40, 10);
    #2 RSTB = 1'b0;
    #1;
    check_eq("midrst0", 32'(st0), 32'h0);
    check_eq("midrst1", 32'(st1), 32'h0);
    @(negedge clock);
    RSTB = 1'b1;
    model_reset();
    checkbits = 16'h0;
    do_start(6, 1'b0);
    hold(16'hAB40, 10);
    check_eq("lost_table", 32'(idx0), 32'd0);
    hold(16'h0, 110);

    // Randomized runs from a small value pool so hits and skips are frequent.
    for (int it = 0; it < 40; it++) begin
      for (int j = 0; j < NCp; j++) tbl[j] = 16'h0040 + 16'($urandom_range(0, 4));
      program_tbl(NCp);
      do_start($urandom_range(0, 10), 1'($urandom_range(0, 1)));
      repeat (40) begin
        if ($urandom_range(0, 9) == 0) do_start($urandom_range(0, 10), 1'($urandom_range(0, 1)));
        hold(16'h0040 + 16'($urandom_range(0, 4)), $urandom_range(1, 6));
      end
      hold(16'h0, 110);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
